// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone command master and its
// LED-sweep slave.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } wb_state_t;

    localparam int WB_AW = 1;
    localparam int WB_DW = 32;

    localparam logic [WB_AW-1:0] STATUS_ADR = 1'b0;

endpackage

// File: rtl/wb_watchdog.sv
// Saturating cycle counter that flags expiry once it reaches TIMEOUT-1.
module wb_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined master: one bus cycle and one
// response per accepted command, with a timeout watchdog.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i,
    input  logic [DW-1:0] wb_dat_i
);

    wb_state_t r_state;
    logic      w_expire;
    logic      w_ack_ok;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_watchdog (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clr    (r_state == IDLE),
        .i_en     (wb_cyc_o),
        .o_expire (w_expire)
    );

    // An ack only counts once the request has left the stall phase.
    assign w_ack_ok    = wb_ack_i && !((r_state == REQ) && wb_stall_i);
    assign cmd_ready_o = (r_state == IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wb_we_o  <= cmd_we_i;
                        wb_adr_o <= cmd_adr_i;
                        wb_dat_o <= cmd_dat_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if ((r_state == REQ) && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                    end
                    // Ack beats a same-cycle timeout.
                    if (w_ack_ok || w_expire) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= !w_ack_ok;
                        if (w_ack_ok && !wb_we_o) begin
                            rsp_dat_o <= wb_dat_i;
                        end
                        r_state <= RSP;
                    end else if (!wb_stall_i) begin
                        r_state <= WAIT;
                    end
                end
                RSP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: a TIMEOUT=64 instance driven by a
// scripted slave, plus a TIMEOUT=8 instance with no slave attached.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_we;
    logic [0:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [0:0]  adr;
    logic [31:0] dato;
    logic        ack, stall;
    logic [31:0] wdat;

    logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_dat2, dato2;
    logic        cyc2, stb2, we2;
    logic [0:0]  adr2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.AW(1), .DW(32), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
        .wb_dat_o(dato), .wb_ack_i(ack), .wb_stall_i(stall), .wb_dat_i(wdat)
    );

    wb_cmd_master #(.AW(1), .DW(32), .TIMEOUT(8)) dut_noslave (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid2), .rsp_dat_o(rsp_dat2), .rsp_err_o(rsp_err2),
        .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2), .wb_adr_o(adr2),
        .wb_dat_o(dato2), .wb_ack_i(1'b0), .wb_stall_i(1'b0), .wb_dat_i(32'h0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one command through the scripted slave and reports what it saw.
    task automatic run_cmd(input logic w, input logic [0:0] a, input logic [31:0] d,
                           input int stalls, input bit zl, input logic [31:0] rdata,
                           output int lat, output logic got_valid, output logic got_err,
                           output logic [31:0] got_dat, output logic got_after,
                           output bit stable);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick;
            n++;
        end
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d;
        tick;
        cmd_valid = 1'b0; cmd_we = ~w; cmd_adr = ~a; cmd_dat = ~d;
        lat = 1;
        stable = (cyc && stb && we == w && adr == a && dato == d);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            ack = (i == 1);
            tick;
            lat++;
            if (!(cyc && stb && we == w && adr == a && dato == d)) stable = 0;
        end
        stall = 1'b0; ack = zl; wdat = rdata;
        tick;
        lat++;
        if (!zl) begin
            ack = 1'b1;
            tick;
            lat++;
        end
        ack = 1'b0; wdat = 32'hBAD0_BAD0;
        got_valid = rsp_valid; got_err = rsp_err; got_dat = rsp_dat;
        tick;
        got_after = rsp_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 0; cmd_valid2 = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0;
        ack = 0; stall = 0; wdat = 0;
        repeat (2) tick;
        checks++;
        if ({cyc, stb, we, adr, rsp_valid, rsp_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000", {cyc, stb, we, adr, rsp_valid, rsp_err});
        end
        checks++;
        if (dato !== 32'h0 || rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got dat_o=%h rsp_dat=%h want 0", dato, rsp_dat);
        end
        rst = 1'b0;
        tick;
        checks++;
        if ({cmd_ready, cyc} !== 2'b10) begin
            failures++;
            $display("FAIL reset_ready: got ready,cyc=%b want 10", {cmd_ready, cyc});
        end
    endtask

    task automatic test_idle_write;
        cmd_valid = 1; cmd_we = 1; cmd_adr = 0; cmd_dat = 0;
        tick;
        cmd_valid = 0;
        checks++;
        if ({cyc, stb, we, cmd_ready} !== 4'b1110) begin
            failures++;
            $display("FAIL iw_req: got cyc,stb,we,ready=%b want 1110", {cyc, stb, we, cmd_ready});
        end
        tick;
        checks++;
        if ({cyc, stb} !== 2'b10) begin
            failures++;
            $display("FAIL iw_wait: got cyc,stb=%b want 10", {cyc, stb});
        end
        ack = 1;
        tick;
        ack = 0;
        checks++;
        if ({cyc, rsp_valid, rsp_err, cmd_ready} !== 4'b0100) begin
            failures++;
            $display("FAIL iw_rsp: got cyc,rv,err,ready=%b want 0100", {cyc, rsp_valid, rsp_err, cmd_ready});
        end
        tick;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL iw_idle: got rv,ready=%b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_stall_write;
        int lat; logic gv, ge, ga; logic [31:0] gd; bit st;
        run_cmd(1'b1, 1'b1, 32'hA5A5_0001, 14, 1'b0, 32'h1234_5678, lat, gv, ge, gd, ga, st);
        checks++;
        if (st !== 1'b1) begin
            failures++;
            $display("FAIL stall_stable: got %0d want 1", st);
        end
        checks++;
        if ({gv, ge, ga} !== 3'b100 || lat != 17) begin
            failures++;
            $display("FAIL stall_rsp: got v,err,after=%b lat=%0d want 100 lat=17", {gv, ge, ga}, lat);
        end
        checks++;
        if (gd !== 32'h0) begin
            failures++;
            $display("FAIL stall_wr_nodata: got %h want 00000000", gd);
        end
    endtask

    task automatic test_read_poll;
        int lat; logic gv, ge, ga; logic [31:0] gd; bit st;
        run_cmd(1'b1, 1'b0, 32'h0, 0, 1'b1, 32'h0, lat, gv, ge, gd, ga, st);
        checks++;
        if ({gv, ge, ga} !== 3'b100 || lat != 2) begin
            failures++;
            $display("FAIL zl_write: got v,err,after=%b lat=%0d want 100 lat=2", {gv, ge, ga}, lat);
        end
        repeat (3) tick;
        run_cmd(1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0000_0004, lat, gv, ge, gd, ga, st);
        checks++;
        if (gd !== 32'h0000_0004 || {gv, ge} !== 2'b10 || lat != 3) begin
            failures++;
            $display("FAIL poll_busy: got dat=%h v,err=%b lat=%0d want 00000004 10 lat=3", gd, {gv, ge}, lat);
        end
        run_cmd(1'b1, 1'b0, 32'h1, 0, 1'b0, 32'hDEAD_BEEF, lat, gv, ge, gd, ga, st);
        checks++;
        if (gd !== 32'h0000_0004) begin
            failures++;
            $display("FAIL wr_keeps_dat: got %h want 00000004", gd);
        end
        run_cmd(1'b0, 1'b0, 32'h0, 2, 1'b0, 32'h0, lat, gv, ge, gd, ga, st);
        checks++;
        if (gd !== 32'h0 || {gv, ge} !== 2'b10 || lat != 5 || st !== 1'b1) begin
            failures++;
            $display("FAIL poll_done: got dat=%h v,err=%b lat=%0d st=%0d want 0 10 lat=5 st=1", gd, {gv, ge}, lat, st);
        end
    endtask

    task automatic test_timeout;
        int high = 0;
        cmd_we = 0; cmd_adr = 0;
        checks++;
        if (cmd_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL to_ready0: got %b want 1", cmd_ready2);
        end
        cmd_valid2 = 1;
        tick;
        cmd_valid2 = 0;
        while (cyc2 && high < 40) begin
            high++;
            tick;
        end
        checks++;
        if (high != 8) begin
            failures++;
            $display("FAIL to_cyc_len: got %0d want 8", high);
        end
        checks++;
        if ({rsp_valid2, rsp_err2, cmd_ready2, stb2} !== 4'b1100) begin
            failures++;
            $display("FAIL to_rsp: got rv,err,ready,stb=%b want 1100", {rsp_valid2, rsp_err2, cmd_ready2, stb2});
        end
        tick;
        checks++;
        if ({rsp_valid2, cmd_ready2, cyc2} !== 3'b010) begin
            failures++;
            $display("FAIL to_after: got rv,ready,cyc=%b want 010", {rsp_valid2, cmd_ready2, cyc2});
        end
    endtask

    task automatic test_back_to_back;
        int accepted = 0, pulses = 0, overlap = 0, bad_gap = 0, last = -1, extra = 0;
        cmd_valid = 1; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; stall = 0; ack = 0;
        for (int c = 0; c < 40 && pulses < 3; c++) begin
            if (cmd_valid && cmd_ready) begin
                accepted++;
                if (cyc) overlap++;
                if (last >= 0 && c - last != 4) bad_gap++;
                last = c;
            end
            ack = cyc && !stb;
            wdat = 32'h100 + accepted;
            tick;
            if (rsp_valid) pulses++;
            if (accepted == 3) cmd_valid = 0;
        end
        ack = 0;
        checks++;
        if (accepted != 3 || pulses != 3) begin
            failures++;
            $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3 3", accepted, pulses);
        end
        checks++;
        if (overlap != 0 || bad_gap != 0) begin
            failures++;
            $display("FAIL b2b_spacing: got overlap=%0d badgap=%0d want 0 0", overlap, bad_gap);
        end
        checks++;
        if (rsp_dat !== 32'h103) begin
            failures++;
            $display("FAIL b2b_data: got %h want 00000103", rsp_dat);
        end
        repeat (6) begin
            tick;
            if (rsp_valid || cyc) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL b2b_quiet: got %0d want 0", extra);
        end
    endtask

    task automatic test_async_reset;
        int bad = 0;
        cmd_valid = 1; cmd_we = 0; cmd_adr = 0; stall = 0; ack = 0;
        tick;
        cmd_valid = 0;
        tick;
        checks++;
        if ({cyc, stb} !== 2'b10) begin
            failures++;
            $display("FAIL ar_wait: got cyc,stb=%b want 10", {cyc, stb});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL ar_drop: got cyc,stb,rv,ready=%b want 0001", {cyc, stb, rsp_valid, cmd_ready});
        end
        #1 rst = 1'b0;
        repeat (4) begin
            tick;
            if (rsp_valid || cyc || !cmd_ready) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ar_after: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_idle_write;
        test_stall_write;
        test_read_poll;
        test_timeout;
        test_back_to_back;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
